// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: two-pass (low nibble, then high nibble) sequencer for the
// 8-bit ALU result and {Z,N,H,C} flag path. One accepted operation takes
// three cycles: LO, HI, DONE. The carry/borrow out of the low pass feeds the
// high pass and also becomes the H flag.
// Optional feature: define ALU_DAA_EN to make op 8 a decimal adjust (DAA);
// without it op 8 behaves as NOP and no DAA logic is built.
module alu_nibble_seq (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [7:0] opa,
  input  logic [7:0] opb,
  input  logic [3:0] flags_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [3:0] flags_out
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_CP  = 4'd7;
`ifdef ALU_DAA_EN
  localparam logic [3:0] OP_DAA = 4'd8;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic       accept;

  // Operation latched at the accepting edge
  logic [3:0] op_l;
  logic [7:0] a_l;
  logic [7:0] b_l;
  logic [3:0] f_l;   // {Z,N,H,C}

  // Low-pass result carried into the high pass
  logic [3:0] lo_nib;
  logic       lo_cy;

  // Shared nibble unit
  logic       is_hi;
  logic [3:0] x_nib;
  logic [3:0] y_nib;
  logic       cin;
  logic       do_sub;
  logic [4:0] nsum;
  logic [3:0] nib_out;
  logic       cy_out;

  // Assembly of the final byte and flags during the high pass
  logic [7:0] full;
  logic       zf;
  logic [7:0] res_nx;
  logic [3:0] flg_nx;

`ifdef ALU_DAA_EN
  logic       daa_lo_adj;
  logic       daa_hi_adj;

  // DAA correction decisions; the high one looks at the original accumulator
  always_comb begin
    if (f_l[2]) begin
      daa_lo_adj = f_l[1];
      daa_hi_adj = f_l[0];
    end else begin
      daa_lo_adj = f_l[1] | (a_l[3:0] > 4'd9);
      daa_hi_adj = f_l[0] | (a_l > 8'h99);
    end
  end
`endif

  // Next-state logic; start is honoured only from IDLE or DONE
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        accept   = 1'b1;
        state_nx = S_LO;
      end
      S_LO:   state_nx = S_HI;
      S_HI:   state_nx = S_DONE;
      S_DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = S_LO;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state == S_LO) || (state == S_HI);
  assign done = (state == S_DONE);

  // Nibble unit: selects the current half of the operands and evaluates op
  always_comb begin
    is_hi  = (state == S_HI);
    x_nib  = is_hi ? a_l[7:4] : a_l[3:0];
    y_nib  = is_hi ? b_l[7:4] : b_l[3:0];
    cin    = is_hi ? lo_cy : (((op_l == OP_ADC) || (op_l == OP_SBC)) ? f_l[0] : 1'b0);
    do_sub = (op_l == OP_SUB) || (op_l == OP_SBC) || (op_l == OP_CP);
`ifdef ALU_DAA_EN
    if (op_l == OP_DAA) begin
      // DAA adds or subtracts 6 in each nibble; N selects the direction
      y_nib  = (is_hi ? daa_hi_adj : daa_lo_adj) ? 4'd6 : 4'd0;
      cin    = is_hi ? lo_cy : 1'b0;
      do_sub = f_l[2];
    end
`endif
    // Bit 4 of the 5-bit result is carry when adding and borrow when subtracting
    nsum = do_sub ? ({1'b0, x_nib} - {1'b0, y_nib} - {4'b0000, cin})
                  : ({1'b0, x_nib} + {1'b0, y_nib} + {4'b0000, cin});
    case (op_l)
      OP_AND: begin
        nib_out = x_nib & y_nib;
        cy_out  = 1'b0;
      end
      OP_XOR: begin
        nib_out = x_nib ^ y_nib;
        cy_out  = 1'b0;
      end
      OP_OR: begin
        nib_out = x_nib | y_nib;
        cy_out  = 1'b0;
      end
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP: begin
        nib_out = nsum[3:0];
        cy_out  = nsum[4];
      end
`ifdef ALU_DAA_EN
      OP_DAA: begin
        nib_out = nsum[3:0];
        cy_out  = nsum[4];
      end
`endif
      default: begin
        nib_out = x_nib;
        cy_out  = 1'b0;
      end
    endcase
  end

  // Final byte and flags, meaningful while in HI
  always_comb begin
    full   = {nib_out, lo_nib};
    zf     = (full == 8'h00);
    res_nx = a_l;
    flg_nx = f_l;
    case (op_l)
      OP_ADD, OP_ADC: begin
        res_nx = full;
        flg_nx = {zf, 1'b0, lo_cy, cy_out};
      end
      OP_SUB, OP_SBC: begin
        res_nx = full;
        flg_nx = {zf, 1'b1, lo_cy, cy_out};
      end
      OP_CP: begin
        // Compare keeps the accumulator but reports the subtraction's flags
        res_nx = a_l;
        flg_nx = {zf, 1'b1, lo_cy, cy_out};
      end
      OP_AND: begin
        res_nx = full;
        flg_nx = {zf, 1'b0, 1'b1, 1'b0};
      end
      OP_XOR, OP_OR: begin
        res_nx = full;
        flg_nx = {zf, 1'b0, 1'b0, 1'b0};
      end
`ifdef ALU_DAA_EN
      OP_DAA: begin
        res_nx = full;
        flg_nx = {zf, f_l[2], 1'b0, f_l[2] ? f_l[0] : daa_hi_adj};
      end
`endif
      default: begin
        res_nx = a_l;
        flg_nx = f_l;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Operand latch, loaded only on an accepted start
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      op_l <= 4'h0;
      a_l  <= 8'h00;
      b_l  <= 8'h00;
      f_l  <= 4'h0;
    end else if (accept) begin
      op_l <= op;
      a_l  <= opa;
      b_l  <= opb;
      f_l  <= flags_in;
    end
  end

  // Low-pass nibble and carry/borrow, captured at the end of LO
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      lo_nib <= 4'h0;
      lo_cy  <= 1'b0;
    end else if (state == S_LO) begin
      lo_nib <= nib_out;
      lo_cy  <= cy_out;
    end
  end

  // Outputs update only on the edge that enters DONE, then hold
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      result    <= 8'h00;
      flags_out <= 4'h0;
    end else if (state == S_HI) begin
      result    <= res_nx;
      flags_out <= flg_nx;
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Testbench for alu_nibble_seq: directed cases plus randomized operations
// checked against a byte-level arithmetic reference model.
module tb_alu_nibble_seq;

  logic       clk;
  logic       nreset;
  logic       start;
  logic [3:0] op;
  logic [7:0] opa;
  logic [7:0] opb;
  logic [3:0] flags_in;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [3:0] flags_out;

  int checks;
  int errors;

  logic [7:0] exp_res;
  logic [3:0] exp_flg;

  alu_nibble_seq dut (
    .clk       (clk),
    .nreset    (nreset),
    .start     (start),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .flags_in  (flags_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .flags_out (flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: whole-byte arithmetic, returns {result, Z, N, H, C}
  function automatic logic [11:0] model(input logic [3:0] o, input logic [7:0] a,
                                        input logic [7:0] b, input logic [3:0] f);
    int ai, bi, ci, s, lo, adj;
    logic [7:0] r;
    logic h, c;
    ai = int'(a);
    bi = int'(b);
    ci = int'(f[0]);
    case (o)
      4'd0, 4'd1: begin
        if (o == 4'd0) ci = 0;
        s  = ai + bi + ci;
        lo = (ai % 16) + (bi % 16) + ci;
        r  = 8'(s);
        h  = (lo > 15);
        c  = (s > 255);
        return {r, (r == 8'h00), 1'b0, h, c};
      end
      4'd2, 4'd3, 4'd7: begin
        if (o != 4'd3) ci = 0;
        s  = ai - bi - ci;
        lo = (ai % 16) - (bi % 16) - ci;
        r  = 8'(s);
        h  = (lo < 0);
        c  = (s < 0);
        if (o == 4'd7) return {a, (r == 8'h00), 1'b1, h, c};
        return {r, (r == 8'h00), 1'b1, h, c};
      end
      4'd4: begin
        r = a & b;
        return {r, (r == 8'h00), 1'b0, 1'b1, 1'b0};
      end
      4'd5: begin
        r = a ^ b;
        return {r, (r == 8'h00), 3'b000};
      end
      4'd6: begin
        r = a | b;
        return {r, (r == 8'h00), 3'b000};
      end
`ifdef ALU_DAA_EN
      4'd8: begin
        adj = 0;
        c   = f[0];
        if (!f[2]) begin
          if (f[1] || (ai % 16) > 9) adj += 6;
          if (f[0] || ai > 153) begin
            adj += 96;
            c = 1'b1;
          end
          r = 8'(ai + adj);
        end else begin
          if (f[1]) adj += 6;
          if (f[0]) adj += 96;
          r = 8'(ai - adj);
        end
        return {r, (r == 8'h00), f[2], 1'b0, c};
      end
`endif
      default: return {a, f};
    endcase
  endfunction

  // One operation from an IDLE or DONE cycle; optional start pulse during LO
  task automatic do_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] f, input bit poke);
    logic [11:0] e;
    e = model(o, a, b, f);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; flags_in = f;
    @(posedge clk); #1;
    start = 1'b0;
    op = 4'($urandom); opa = 8'($urandom); opb = 8'($urandom); flags_in = 4'($urandom);
    chk("busy_lo", busy, 1);
    chk("done_lo", done, 0);
    if (poke) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_hi", busy, 1);
    chk("done_hi", done, 0);
    chk("held_res_hi", result, exp_res);
    chk("held_flg_hi", flags_out, exp_flg);
    @(posedge clk); #1;
    exp_res = e[11:4];
    exp_flg = e[3:0];
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
    chk($sformatf("res op%0d %h,%h f%h", o, a, b, f), result, exp_res);
    chk($sformatf("flg op%0d %h,%h f%h", o, a, b, f), flags_out, exp_flg);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("done_idle", done, 0);
    chk("busy_idle", busy, 0);
    chk("held_res", result, exp_res);
    chk("held_flg", flags_out, exp_flg);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    exp_res = 8'h00;
    exp_flg = 4'h0;
    nreset = 1'b0;
    start = 1'b0;
    op = 4'h0; opa = 8'h00; opb = 8'h00; flags_in = 4'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 8'h00);
    chk("rst_flg", flags_out, 4'h0);
    @(negedge clk);
    nreset = 1'b1;
    idle_cycle();

    // Directed cases
    do_op(4'd3, 8'hFF, 8'hFF, 4'b0001, 1'b0);
    do_op(4'd2, 8'h10, 8'h01, 4'b0000, 1'b0);
    do_op(4'd2, 8'h80, 8'h81, 4'b0000, 1'b0);
    do_op(4'd7, 8'h11, 8'h11, 4'b0000, 1'b1);
    idle_cycle();
    do_op(4'd0, 8'h0F, 8'h01, 4'b0000, 1'b0);
    do_op(4'd1, 8'hFF, 8'h00, 4'b0001, 1'b1);
    do_op(4'd4, 8'hF0, 8'h0F, 4'b0000, 1'b0);
    do_op(4'd5, 8'hA5, 8'hA5, 4'b1111, 1'b0);
    do_op(4'd6, 8'h00, 8'h00, 4'b0101, 1'b0);
    do_op(4'd12, 8'h5A, 8'h33, 4'b1010, 1'b0);
    do_op(4'd0, 8'h15, 8'h27, 4'b0000, 1'b0);
    chk("daa_pre_res", result, 8'h3C);
    do_op(4'd8, 8'h3C, 8'h00, 4'b0000, 1'b0);
`ifdef ALU_DAA_EN
    chk("daa_res", result, 8'h42);
    chk("daa_flg", flags_out, 4'b0000);
`else
    chk("daa_off_res", result, 8'h3C);
    chk("daa_off_flg", flags_out, 4'b0000);
`endif
    idle_cycle();

    // Reset in the middle of an operation
    do_op(4'd0, 8'h0F, 8'h01, 4'b0000, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 4'd2; opa = 8'h55; opb = 8'h12; flags_in = 4'h0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_busy_lo", busy, 1);
    nreset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res", result, 8'h00);
    chk("abort_flg", flags_out, 4'h0);
    exp_res = 8'h00;
    exp_flg = 4'h0;
    @(negedge clk);
    nreset = 1'b1;
    repeat (4) idle_cycle();

    // Randomized operations, back-to-back with occasional gaps and pokes
    for (int i = 0; i < 300; i++) begin
      logic [3:0] ro;
      ro = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) ro = 4'($urandom);
      do_op(ro, 8'($urandom), 8'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
